// File: rtl/cia_serial_link.sv
// Byte-level serial peer for the CIA SP/CNT pins: receives bytes clocked out by the CIA
// on CNT rising edges and transmits host bytes MSB-first while generating CNT itself.
module cia_serial_link #(
  parameter int CNT_HALF   = 4,
  parameter int RX_TIMEOUT = 64,
  parameter int GAP        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       phi2_p,
  input  logic       cia_sp_out,
  input  logic       cia_cnt_out,
  output logic       cia_sp_in,
  output logic       cia_cnt_in,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, TAIL} tx_state_t;

  localparam logic [15:0] HALF_LAST = 16'(CNT_HALF - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP - 1);
  localparam logic [15:0] TO_LAST   = 16'(RX_TIMEOUT - 1);

  logic        cnt_prev;
  logic [6:0]  shift_rx;
  logic [2:0]  rx_cnt;
  logic [15:0] rx_to;
  logic        rx_rise;
  logic        rx_active;

  tx_state_t   state;
  logic [15:0] tick;
  logic [2:0]  tx_bit;
  logic [7:0]  shift_tx;

  assign rx_rise   = cia_cnt_out & ~cnt_prev;
  assign rx_active = (rx_cnt != 3'd0);
  assign tx_ready  = (state == IDLE) & ~rx_active;
  assign busy      = rx_active | (state != IDLE);

  // Receive: edges are detected every clk; only the mid-byte timeout is paced by phi2_p,
  // and a coincident edge takes priority over the timeout expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_prev <= 1'b1;
      shift_rx <= '0;
      rx_cnt   <= '0;
      rx_to    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      cnt_prev <= cia_cnt_out;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      if (rx_rise) begin
        shift_rx <= {shift_rx[5:0], cia_sp_out};
        rx_cnt   <= rx_cnt + 3'd1;
        rx_to    <= '0;
        if (rx_cnt == 3'd7) begin
          rx_data  <= {shift_rx, cia_sp_out};
          rx_valid <= 1'b1;
        end
      end else if (rx_active && phi2_p) begin
        if (rx_to == TO_LAST) begin
          rx_cnt   <= '0;
          rx_to    <= '0;
          shift_rx <= '0;
          rx_error <= 1'b1;
        end else begin
          rx_to <= rx_to + 16'd1;
        end
      end
    end
  end

  // Transmit: SP/CNT are registered and updated on the state transitions themselves,
  // so the pins change in the same clk the state does.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tick       <= '0;
      tx_bit     <= '0;
      shift_tx   <= '0;
      cia_cnt_in <= 1'b1;
      cia_sp_in  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shift_tx   <= tx_data;
            tx_bit     <= '0;
            tick       <= '0;
            cia_cnt_in <= 1'b0;
            cia_sp_in  <= tx_data[7];
            state      <= LOW;
          end
        end
        LOW: begin
          if (phi2_p) begin
            if (tick == HALF_LAST) begin
              tick       <= '0;
              cia_cnt_in <= 1'b1;
              state      <= HIGH;
            end else begin
              tick <= tick + 16'd1;
            end
          end
        end
        HIGH: begin
          if (phi2_p) begin
            if (tick == HALF_LAST) begin
              tick <= '0;
              if (tx_bit == 3'd7) begin
                cia_sp_in <= 1'b1;
                state     <= TAIL;
              end else begin
                shift_tx   <= {shift_tx[6:0], 1'b0};
                cia_sp_in  <= shift_tx[6];
                tx_bit     <= tx_bit + 3'd1;
                cia_cnt_in <= 1'b0;
                state      <= LOW;
              end
            end else begin
              tick <= tick + 16'd1;
            end
          end
        end
        TAIL: begin
          if (phi2_p) begin
            if (tick == GAP_LAST) begin
              tick  <= '0;
              state <= IDLE;
            end else begin
              tick <= tick + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cia_serial_link.sv
// Directed bench for cia_serial_link with default parameters (CNT_HALF=4, RX_TIMEOUT=64,
// GAP=8) and phi2_p pulsing once every 8 clks.
module tb_cia_serial_link;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       phi2_p = 1'b0;
  logic       cia_sp_out = 1'b1;
  logic       cia_cnt_out = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       cia_sp_in;
  logic       cia_cnt_in;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int rxCount = 0;
  int errCount = 0;
  logic [7:0] lastRx = 8'h00;

  int ticks;
  int lowTicks;
  int rises;
  logic prevCnt;
  logic [7:0] sampled;
  logic [7:0] byteVal;

  cia_serial_link dut (
    .clk        (clk),
    .reset      (reset),
    .phi2_p     (phi2_p),
    .cia_sp_out (cia_sp_out),
    .cia_cnt_out(cia_cnt_out),
    .cia_sp_in  (cia_sp_in),
    .cia_cnt_in (cia_cnt_in),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_error   (rx_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // phi2_p strobe: one clk high every 8 clks, changed just after the rising edge
  initial begin
    forever begin
      repeat (7) @(posedge clk);
      #1 phi2_p = 1'b1;
      @(posedge clk);
      #1 phi2_p = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rx_valid) begin
      rxCount <= rxCount + 1;
      lastRx  <= rx_data;
    end
    if (rx_error) errCount <= errCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic stepClk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One CIA-style bit: SP changes with CNT low, CNT rises half a bit later
  task automatic applyStimulus(input logic b);
    cia_cnt_out = 1'b0;
    cia_sp_out  = b;
    stepClk(4);
    cia_cnt_out = 1'b1;
    stepClk(4);
  endtask

  initial begin
    // Reset with CNT held high
    stepClk(3);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_cnt_in", cia_cnt_in, 1);
    checkOutput("reset_sp_in", cia_sp_in, 1);
    checkOutput("reset_tx_ready", tx_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rx_data", rx_data, 8'h00);
    stepClk(100);
    checkOutput("idle_no_rx_valid", rxCount, 0);
    checkOutput("idle_no_rx_error", errCount, 0);

    // Receive 8'hA5
    byteVal = 8'hA5;
    for (int i = 7; i >= 0; i--) applyStimulus(byteVal[i]);
    checkOutput("rx_a5_count", rxCount, 1);
    checkOutput("rx_a5_data", lastRx, 8'hA5);
    checkOutput("rx_a5_port", rx_data, 8'hA5);
    checkOutput("rx_a5_busy", busy, 0);

    // Transmit 8'h3C and measure the frame
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    @(negedge clk);
    checkOutput("tx_start_cnt", cia_cnt_in, 0);
    checkOutput("tx_start_sp", cia_sp_in, 0);
    checkOutput("tx_start_ready", tx_ready, 0);
    checkOutput("tx_start_busy", busy, 1);
    ticks = 0; lowTicks = 0; rises = 0; prevCnt = 1'b0; sampled = 8'h00;
    for (int i = 0; i < 2000; i++) begin
      if (tx_ready) break;
      if (!prevCnt && cia_cnt_in) begin
        rises++;
        sampled = {sampled[6:0], cia_sp_in};
      end
      prevCnt = cia_cnt_in;
      if (phi2_p) begin
        ticks++;
        if (!cia_cnt_in) lowTicks++;
      end
      @(negedge clk);
    end
    checkOutput("tx_3c_ready_back", tx_ready, 1);
    checkOutput("tx_3c_ticks", ticks, 72);
    checkOutput("tx_3c_low_ticks", lowTicks, 32);
    checkOutput("tx_3c_rises", rises, 8);
    checkOutput("tx_3c_sampled", sampled, 8'h3C);
    checkOutput("tx_3c_idle_sp", cia_sp_in, 1);
    @(posedge clk); #1;

    // Three edges then silence: timeout after 64 ticks
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    cia_cnt_out = 1'b0;
    cia_sp_out  = 1'b1;
    stepClk(4);
    cia_cnt_out = 1'b1;
    @(posedge clk);
    ticks = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rx_error) break;
      if (phi2_p) ticks++;
    end
    checkOutput("timeout_error_pulse", rx_error, 1);
    checkOutput("timeout_ticks", ticks, 64);
    checkOutput("timeout_busy", busy, 0);
    checkOutput("timeout_no_valid", rx_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("timeout_single_pulse", rx_error, 0);
    checkOutput("timeout_err_count", errCount, 1);
    @(posedge clk); #1;
    byteVal = 8'hFF;
    for (int i = 7; i >= 0; i--) applyStimulus(byteVal[i]);
    checkOutput("rx_ff_data", lastRx, 8'hFF);
    checkOutput("rx_ff_count", rxCount, 2);

    // Partial receive blocks a pending transmit until the byte completes
    byteVal = 8'h96;
    tx_data = 8'h81;
    applyStimulus(byteVal[7]);
    applyStimulus(byteVal[6]);
    tx_valid = 1'b1;
    @(negedge clk);
    checkOutput("partial_ready_low", tx_ready, 0);
    checkOutput("partial_busy", busy, 1);
    @(posedge clk); #1;
    for (int i = 5; i >= 1; i--) applyStimulus(byteVal[i]);
    @(negedge clk);
    checkOutput("partial7_ready_low", tx_ready, 0);
    checkOutput("partial7_no_tx", cia_cnt_in, 1);
    @(posedge clk); #1;
    cia_cnt_out = 1'b0;
    cia_sp_out  = byteVal[0];
    stepClk(4);
    cia_cnt_out = 1'b1;
    @(negedge clk);
    checkOutput("edge8_ready_low", tx_ready, 0);
    @(negedge clk);
    checkOutput("edge8_ready_high", tx_ready, 1);
    checkOutput("edge8_rx_valid", rx_valid, 1);
    checkOutput("edge8_rx_data", rx_data, 8'h96);
    @(negedge clk);
    tx_valid = 1'b0;
    checkOutput("blocked_tx_cnt", cia_cnt_in, 0);
    checkOutput("blocked_tx_sp", cia_sp_in, 1);
    checkOutput("blocked_tx_ready", tx_ready, 0);
    for (int i = 0; i < 2000; i++) begin
      if (tx_ready) break;
      @(negedge clk);
    end
    checkOutput("blocked_tx_done", tx_ready, 1);
    @(posedge clk); #1;

    // Reset in the middle of a transmit (HIGH phase of bit 4)
    tx_data  = 8'hF0;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    rises = 0;
    prevCnt = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!prevCnt && cia_cnt_in) rises++;
      prevCnt = cia_cnt_in;
      if (rises == 5) break;
    end
    checkOutput("midtx_rises", rises, 5);
    checkOutput("midtx_bit4_sp", cia_sp_in, 0);
    checkOutput("midtx_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midtx_reset_cnt", cia_cnt_in, 1);
    checkOutput("midtx_reset_sp", cia_sp_in, 1);
    checkOutput("midtx_reset_ready", tx_ready, 1);
    checkOutput("midtx_reset_busy", busy, 0);
    checkOutput("midtx_reset_rx_valid", rx_valid, 0);
    checkOutput("midtx_reset_rx_error", rx_error, 0);
    reset = 1'b0;
    stepClk(20);
    checkOutput("final_rx_count", rxCount, 3);
    checkOutput("final_err_count", errCount, 1);
    checkOutput("final_cnt_idle", cia_cnt_in, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cia_serial_link.md
# cia_serial_link

Byte-level serial peer for the CIA serial port, sitting directly on the CIA SP/CNT pins.
- Receive: deserializes bytes the CIA shifts out when its serial port is in output mode, and presents them on a valid-pulse interface.
- Transmit: serializes host bytes onto SP while generating CNT, so the CIA captures them in input mode.
- Used by fast-serial and burst peripherals and test harnesses that exchange SDR traffic with the CIA.

## Interface
- CNT_HALF, 4: transmit CNT half-period, in phi2_p ticks (legal 1..255).
- RX_TIMEOUT, 64: phi2_p ticks without a CNT rising edge mid-byte before the partial byte is dropped (legal 2..65535).
- GAP, 8: phi2_p ticks of idle high CNT after a transmitted byte, before tx_ready re-asserts.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- phi2_p  in  1  one-clk strobe, Phi2 positive edge; all timing counters advance only on it.
- cia_sp_out  in  1  CIA SP output (data from the CIA).
- cia_cnt_out  in  1  CIA CNT output (CIA shift clock).
- cia_sp_in  out  1  SP driven toward the CIA.
- cia_cnt_in  out  1  CNT driven toward the CIA.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  transmit request.
- tx_ready  out  1  high when a byte can be accepted.
- rx_data  out  8  last received byte.
- rx_valid  out  1  one-clk pulse, rx_data updated.
- rx_error  out  1  one-clk pulse, partial byte dropped on timeout.
- busy  out  1  receive or transmit in progress.

## Operation
- **Bit order:** MSB first in both directions.
- **Receive path**
  - cnt_prev <= cia_cnt_out every clk.
  - A rising edge is cia_cnt_out & ~cnt_prev, checked every clk, not gated by phi2_p.
  - On each rising edge: shift_rx <= {shift_rx[6:0], cia_sp_out}, rx_cnt[2:0] increments, and the timeout counter clears.
  - When the edge is the 8th (rx_cnt == 7 before the increment): rx_data <= {shift_rx[6:0], cia_sp_out}, rx_valid pulses, rx_cnt wraps to 0.
  - While rx_cnt != 0, the timeout counter increments on each phi2_p. When it reaches RX_TIMEOUT: rx_cnt <= 0, shift_rx is discarded, rx_error pulses for one clk.
  - rx_active = (rx_cnt != 0).
- **Transmit FSM**
  - States: IDLE, LOW, HIGH, TAIL. A tick counter counts phi2_p; tx_bit[2:0] holds the bit index.
  - IDLE: cia_cnt_in = 1, cia_sp_in = 1. tx_ready = ~rx_active.
    - On tx_valid & tx_ready: latch tx_data into shift_tx, tx_bit <= 0, go to LOW.
  - LOW: cia_cnt_in = 0, cia_sp_in = shift_tx[7].
    - After CNT_HALF phi2_p ticks, go to HIGH (this is the rising edge; the CIA samples SP here).
  - HIGH: cia_cnt_in = 1, cia_sp_in is held.
    - After CNT_HALF ticks: if tx_bit == 7, go to TAIL; else shift_tx <<= 1, tx_bit++, go to LOW.
  - TAIL: cia_cnt_in = 1, cia_sp_in = 1. After GAP ticks, go to IDLE.
  - tx_ready = 0 in LOW, HIGH and TAIL.
- **Direction contention:** receive edges are always captured, even while transmitting; the bus is not arbitrated. The host must not transmit while the CIA is in output mode. tx_ready blocks only while a received byte is partially in progress.
- busy = rx_active | (state != IDLE).
- **Reset:** clears every register, with these values:
  - State IDLE.
  - cia_cnt_in = 1, cia_sp_in = 1.
  - tx_ready = 1.
  - rx_data = 8'h00, rx_valid = 0, rx_error = 0, busy = 0.
  - rx_cnt = 0, all counters = 0.
  - Reset mid-byte aborts without emitting rx_valid or rx_error. cnt_prev resets to 1, so a CNT that is high at reset release is not an edge.

## Timing
- **tx_ready:** combinational from state and rx_cnt.
- **Handshake:** a transfer occurs in the clk where tx_valid & tx_ready are both high.
  - In the next clk: state is LOW, cia_cnt_in = 0, cia_sp_in = tx_data[7].
- **Frame length:** each bit is 2*CNT_HALF phi2_p ticks. The frame is 16*CNT_HALF + GAP ticks from acceptance to tx_ready.
- **Phase measurement:** tick counting starts at the first phi2_p after the state entry.
- **Receive latency:** rx_valid asserts in the clk after the clk where the 8th rising edge is detected, with rx_data valid in that same clk.
- **Pulse rules:** rx_valid and rx_error never assert in the same clk. A rising edge in the same clk as the timeout expiry wins: the bit is shifted and the counter cleared.
- **Outputs:** cia_sp_in and cia_cnt_in are registered.

## Test plan
- Reset release with cia_cnt_out held high -> cia_cnt_in = 1, cia_sp_in = 1, tx_ready = 1, no rx_valid for 100 clks.
- CIA-style frame for 8'hA5 (SP changes on CNT falling edges, 8 rising edges) -> a single rx_valid with rx_data = 8'hA5.
- Send tx_data = 8'h3C with CNT_HALF = 4, phi2_p every 8 clk -> CNT shows 8 low/high pulses of 4 phi2_p each. SP at each rising edge reads 0,0,1,1,1,1,0,0. tx_ready returns after 72 ticks.
- Three rising edges, then none -> rx_error pulses exactly RX_TIMEOUT phi2_p ticks after the last edge. A following full 8'hFF frame gives rx_data = 8'hFF.
- Partial receive (rx_cnt = 2) with tx_valid held -> tx_ready stays 0 until the byte completes, then the transmit starts the next clk.
- Assert reset mid-transmit (state HIGH, bit 4) -> the next clk shows IDLE outputs and tx_ready = 1, with no rx_valid or rx_error.
